wb_commit_arbiter: RTL and testbench
====================================

# wb_commit_arbiter

Parametrised writeback/commit stage for the trinity backend. It accepts results from `NUM_CH` execution channels (ALU/BJU, MEM, MULDIV, …) over valid/ready handshakes and buffers one entry per channel. Each cycle it arbitrates one entry into a single writeback register that drives the integer regfile write port and the bypass. It also produces a registered in-order commit trace with MMIO skip, for difftest.

## Interface
Parameters:
- `NUM_CH`, 2: number of result channels (2..8)
- `XLEN`, 64: result/address width
- `ARB_MODE`, 0: 0 = fixed priority (lowest index wins), 1 = round-robin
- `MMIO_LO`, 64'h3000_0000: inclusive lower MMIO bound
- `MMIO_HI`, 64'h4070_0000: inclusive upper MMIO bound

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clock` in 1: sole clock
  - `reset_n` in 1: asynchronous, active-low reset
- Flush:
  - `flush` in 1: discard all buffered and WB-stage entries
- Channel inputs, flat packed with channel i at slice i:
  - `ch_valid` in NUM_CH: result offered
  - `ch_ready` out NUM_CH: channel may hand over this cycle
  - `ch_rd` in NUM_CH*5: destination lreg
  - `ch_need_to_wb` in NUM_CH: writes regfile
  - `ch_is_load` in NUM_CH: load result
  - `ch_is_ls` in NUM_CH: load or store
  - `ch_ls_address` in NUM_CH*XLEN: effective address (valid when `ch_is_ls`)
  - `ch_result` in NUM_CH*XLEN: writeback data
  - `ch_pc` in NUM_CH*64: instruction pc
  - `ch_instr` in NUM_CH*32: instruction word
- Regfile write port:
  - `regfile_write_valid` out 1
  - `regfile_write_rd` out 5
  - `regfile_write_data` out XLEN
- Bypass:
  - `wb_byp_need_to_wb` out 1
  - `wb_byp_rd` out 5
  - `wb_byp_result` out XLEN
- Commit trace:
  - `commit_valid` out 1
  - `commit_rfwen` out 1
  - `commit_skip` out 1
  - `commit_rd` out 5
  - `commit_pc` out 64
  - `commit_instr` out 32
- Counter:
  - `commit_count` out 64: number of committed instructions

## Operation
- Per channel, a 1-entry buffer with occupancy bit `occ[i]`.
  - `ch_ready[i] = ~occ[i] | grant[i]`. `grant` depends only on `occ` and the RR pointer, never on `ch_valid`.
  - Accept on `ch_valid[i] & ch_ready[i]`.
- Arbitration over `occ` picks at most one `grant` per cycle.
  - `ARB_MODE=0`: lowest index wins.
  - `ARB_MODE=1`: first occupied index at or after `rr_ptr`, wrapping from `NUM_CH-1` to 0. On a grant, `rr_ptr` becomes (winner+1) mod NUM_CH; otherwise it holds.
- Simultaneous grant and accept on the same channel: the old entry moves to the WB register and the new entry is written into the buffer (buffer stays full, no bubble).
- WB register loads the granted entry each cycle. `wb_valid` equals "any grant".
- `mmio = is_ls & (MMIO_LO <= addr) & (addr <= MMIO_HI)`, computed at grant and stored.
- Regfile write: `regfile_write_valid = wb_valid & need_to_wb & (rd != 0) & ~(mmio & is_load)`. The bypass outputs mirror the WB register (`wb_byp_need_to_wb` uses the same gating).
- `commit_*` outputs are a one-cycle-registered copy of the WB register:
  - `commit_valid` = wb_valid
  - `commit_rfwen` = regfile_write_valid
  - `commit_skip` = mmio
- `commit_count` increments by 1 per `commit_valid`. It wraps at 2^64.
- Flush, in the cycle `flush=1`:
  - all `occ` cleared; `ch_ready` forced 0 and nothing is accepted;
  - no grant; WB register `wb_valid` cleared at the edge;
  - `rr_ptr` unchanged.
  - A commit already registered still appears on `commit_*` that cycle.

## Timing
- Input accepted at edge N → buffered. Granted during cycle N+1 → regfile write and bypass visible during cycle N+2 → `commit_*` visible during cycle N+3.
- Minimum latency: 2 cycles from accept to regfile write.
- Throughput: 1 writeback per cycle, aggregate over all channels. Sustained per-channel rate of 1/cycle only when uncontended.
- Reset values:
  - all `occ`, `wb_valid`, `regfile_write_valid`, `wb_byp_need_to_wb`, `commit_*` = 0
  - `rr_ptr` = 0; `commit_count` = 0
  - data outputs = 0
- Reset asserted mid-operation drops all in-flight entries with no commit emitted.

## Configuration
- `TRINITY_DIFFTEST_EN` defined:
  - `commit_*` and `commit_count` are driven as above.
  - MMIO classification feeds `commit_skip`.
- Not defined:
  - `commit_*` and `commit_count` are tied to 0 and their flops are removed.
  - The MMIO load suppression on `regfile_write_valid` is retained.

## Structure
- Shared package (`trinity_pkg`) holds:
  - typedef `wb_entry_t` (rd, need_to_wb, is_load, is_ls, mmio, result, pc, instr);
  - constants `ARB_FIXED`, `ARB_RR`;
  - default MMIO bounds.
- Sub-module `rr_arbiter` (NUM_CH request vector, `ARB_MODE`, registered pointer, one-hot grant) instantiated once.

## Test plan
- Single channel: ch0 valid at cycle 1 with rd=5, result=64'h1234 → `regfile_write_valid` at cycle 3 with rd=5, data=64'h1234; `commit_valid` at cycle 4; `commit_count`=1.
- Contention, `ARB_MODE=1`, NUM_CH=3: all channels valid every cycle → grants cycle 0,1,2,0,…; no channel starves; one write per cycle.
- Contention, `ARB_MODE=0`: ch0 and ch1 continuously valid → ch1 never granted while ch0 is occupied; `ch_ready[1]`=0 after its first accept.
- MMIO load: `ch_is_load`=1, `ch_is_ls`=1, addr=64'h3000_0008, rd=7 → `regfile_write_valid`=0, `commit_valid`=1, `commit_skip`=1. Addr 64'h4070_0001 → `commit_skip`=0 and the write occurs.
- rd=0 with `need_to_wb`=1 → no regfile write, `commit_rfwen`=0, commit still counted.
- Flush with 2 buffered entries and WB valid → zero writes afterwards; only an already-registered commit appears; `rr_ptr` unchanged. Reset mid-stream → all outputs 0 and `commit_count`=0.

Source files
------------

// File: rtl/trinity_pkg.sv
// Shared types and constants for the trinity writeback/commit path.
package trinity_pkg;

    localparam int unsigned RD_W     = 5;
    localparam int unsigned PC_W     = 64;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned XLEN_MAX = 64;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    localparam logic [63:0] MMIO_LO_DEF = 64'h0000_0000_3000_0000;
    localparam logic [63:0] MMIO_HI_DEF = 64'h0000_0000_4070_0000;

    typedef struct packed {
        logic [RD_W-1:0]     rd;
        logic                need_to_wb;
        logic                is_load;
        logic                is_ls;
        logic                mmio;
        logic [XLEN_MAX-1:0] result;
        logic [PC_W-1:0]     pc;
        logic [INSTR_W-1:0]  instr;
    } wb_entry_t;

    // Inclusive MMIO window test, only meaningful for loads/stores.
    function automatic logic in_mmio(input logic is_ls, input logic [63:0] addr,
                                     input logic [63:0] lo, input logic [63:0] hi);
        return is_ls && (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: fixed priority (lowest index) or round-robin from a registered pointer.
module rr_arbiter
    import trinity_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned ARB_MODE = ARB_FIXED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] base;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] win;
    logic             found;

    // Scan from the base index with wrap; first requester wins.
    always_comb begin
        grant = '0;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        base  = (ARB_MODE == ARB_RR) ? ptr_q : '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = PTR_W'((32'(base) + k) % NUM_CH);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) begin
            grant[win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= PTR_W'((32'(win) + 1) % NUM_CH);
        end
    end

endmodule

// File: rtl/wb_commit_arbiter.sv
// Writeback/commit stage: per-channel 1-entry buffers, single WB register, commit trace.
// Commit trace and counter exist only when TRINITY_DIFFTEST_EN is defined.
module wb_commit_arbiter
    import trinity_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned ARB_MODE = ARB_FIXED,
    parameter logic [63:0] MMIO_LO  = MMIO_LO_DEF,
    parameter logic [63:0] MMIO_HI  = MMIO_HI_DEF
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic [NUM_CH-1:0]         ch_valid,
    output logic [NUM_CH-1:0]         ch_ready,
    input  logic [NUM_CH*RD_W-1:0]    ch_rd,
    input  logic [NUM_CH-1:0]         ch_need_to_wb,
    input  logic [NUM_CH-1:0]         ch_is_load,
    input  logic [NUM_CH-1:0]         ch_is_ls,
    input  logic [NUM_CH*XLEN-1:0]    ch_ls_address,
    input  logic [NUM_CH*XLEN-1:0]    ch_result,
    input  logic [NUM_CH*PC_W-1:0]    ch_pc,
    input  logic [NUM_CH*INSTR_W-1:0] ch_instr,
    output logic                      regfile_write_valid,
    output logic [RD_W-1:0]           regfile_write_rd,
    output logic [XLEN-1:0]           regfile_write_data,
    output logic                      wb_byp_need_to_wb,
    output logic [RD_W-1:0]           wb_byp_rd,
    output logic [XLEN-1:0]           wb_byp_result,
    output logic                      commit_valid,
    output logic                      commit_rfwen,
    output logic                      commit_skip,
    output logic [RD_W-1:0]           commit_rd,
    output logic [PC_W-1:0]           commit_pc,
    output logic [INSTR_W-1:0]        commit_instr,
    output logic [63:0]               commit_count
);

    logic [NUM_CH-1:0] occ_q;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] accept;
    logic              any_grant;

    wb_entry_t   in_entry [NUM_CH];
    logic [63:0] in_addr  [NUM_CH];
    wb_entry_t   buf_q    [NUM_CH];
    logic [63:0] addr_q   [NUM_CH];

    wb_entry_t   gnt_entry;
    logic [63:0] gnt_addr;
    logic        gnt_wen;

    wb_entry_t   wb_q;
    logic        wb_valid_q;
    logic        wb_wen_q;
    logic        unused_wb;

    // Unpack the flat channel buses into per-channel entries.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            in_entry[i]            = '0;
            in_entry[i].rd         = ch_rd[i*RD_W +: RD_W];
            in_entry[i].need_to_wb = ch_need_to_wb[i];
            in_entry[i].is_load    = ch_is_load[i];
            in_entry[i].is_ls      = ch_is_ls[i];
            in_entry[i].result     = XLEN_MAX'(ch_result[i*XLEN +: XLEN]);
            in_entry[i].pc         = ch_pc[i*PC_W +: PC_W];
            in_entry[i].instr      = ch_instr[i*INSTR_W +: INSTR_W];
            in_addr[i]             = 64'(ch_ls_address[i*XLEN +: XLEN]);
        end
    end

    assign req       = flush ? '0 : occ_q;
    assign any_grant = |grant;
    assign ch_ready  = flush ? '0 : (~occ_q | grant);
    assign accept    = ch_valid & ch_ready;

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk   (clock),
        .rst_n (reset_n),
        .req   (req),
        .grant (grant)
    );

    // Select the granted entry; MMIO class and regfile enable are resolved here.
    always_comb begin
        gnt_entry = '0;
        gnt_addr  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                gnt_entry = buf_q[i];
                gnt_addr  = addr_q[i];
            end
        end
        gnt_entry.mmio = in_mmio(gnt_entry.is_ls, gnt_addr, MMIO_LO, MMIO_HI);
        gnt_wen = any_grant & gnt_entry.need_to_wb & (gnt_entry.rd != '0)
                & ~(gnt_entry.mmio & gnt_entry.is_load);
    end

    // Channel buffers: a same-cycle grant and accept keeps the slot full.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                buf_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                occ_q[i] <= ~flush & (accept[i] | (occ_q[i] & ~grant[i]));
                if (accept[i]) begin
                    buf_q[i]  <= in_entry[i];
                    addr_q[i] <= in_addr[i];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_wen_q   <= 1'b0;
        end else begin
            wb_valid_q <= any_grant;
            wb_wen_q   <= gnt_wen;
            if (any_grant) begin
                wb_q <= gnt_entry;
            end
        end
    end

    assign regfile_write_valid = wb_wen_q;
    assign regfile_write_rd    = wb_q.rd;
    assign regfile_write_data  = XLEN'(wb_q.result);
    assign wb_byp_need_to_wb   = wb_wen_q;
    assign wb_byp_rd           = wb_q.rd;
    assign wb_byp_result       = XLEN'(wb_q.result);

    assign unused_wb = ^{wb_q.need_to_wb, wb_q.is_load, wb_q.is_ls};

`ifdef TRINITY_DIFFTEST_EN
    logic               cm_valid_q;
    logic               cm_rfwen_q;
    logic               cm_skip_q;
    logic [RD_W-1:0]    cm_rd_q;
    logic [PC_W-1:0]    cm_pc_q;
    logic [INSTR_W-1:0] cm_instr_q;
    logic [63:0]        cm_count_q;
    logic               cm_fire;

    // A WB entry caught by flush is discarded and never reaches the trace.
    assign cm_fire = wb_valid_q & ~flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cm_valid_q <= 1'b0;
            cm_rfwen_q <= 1'b0;
            cm_skip_q  <= 1'b0;
            cm_rd_q    <= '0;
            cm_pc_q    <= '0;
            cm_instr_q <= '0;
            cm_count_q <= '0;
        end else begin
            cm_valid_q <= cm_fire;
            cm_rfwen_q <= cm_fire & wb_wen_q;
            cm_skip_q  <= cm_fire & wb_q.mmio;
            cm_count_q <= cm_count_q + 64'(cm_fire);
            if (cm_fire) begin
                cm_rd_q    <= wb_q.rd;
                cm_pc_q    <= wb_q.pc;
                cm_instr_q <= wb_q.instr;
            end
        end
    end

    assign commit_valid = cm_valid_q;
    assign commit_rfwen = cm_rfwen_q;
    assign commit_skip  = cm_skip_q;
    assign commit_rd    = cm_rd_q;
    assign commit_pc    = cm_pc_q;
    assign commit_instr = cm_instr_q;
    assign commit_count = cm_count_q;
`else
    logic unused_trace;

    assign unused_trace = ^{wb_valid_q, wb_q.mmio, wb_q.pc, wb_q.instr};

    assign commit_valid = 1'b0;
    assign commit_rfwen = 1'b0;
    assign commit_skip  = 1'b0;
    assign commit_rd    = '0;
    assign commit_pc    = '0;
    assign commit_instr = '0;
    assign commit_count = '0;
`endif

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Directed bench: fixed-priority 2-channel and round-robin 3-channel instances.
module tb_wb_commit_arbiter;

`ifdef TRINITY_DIFFTEST_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    // fixed-priority instance
    logic [1:0]   fx_valid, fx_ready, fx_need, fx_load, fx_ls;
    logic [9:0]   fx_rd;
    logic [127:0] fx_addr, fx_res, fx_pc;
    logic [63:0]  fx_instr;
    logic         fx_wen, fx_bneed, fx_cv, fx_crf, fx_csk;
    logic [4:0]   fx_wrd, fx_brd, fx_crd;
    logic [63:0]  fx_wdata, fx_bres, fx_cpc, fx_ccnt;
    logic [31:0]  fx_cinstr;

    // round-robin instance
    logic [2:0]   rr_valid, rr_ready, rr_need, rr_load, rr_ls;
    logic [14:0]  rr_rd;
    logic [191:0] rr_addr, rr_res, rr_pc;
    logic [95:0]  rr_instr;
    logic         rr_wen, rr_bneed, rr_cv, rr_crf, rr_csk;
    logic [4:0]   rr_wrd, rr_brd, rr_crd;
    logic [63:0]  rr_wdata, rr_bres, rr_cpc, rr_ccnt;
    logic [31:0]  rr_cinstr;

    wb_commit_arbiter #(.NUM_CH(2), .XLEN(64), .ARB_MODE(0)) u_fx (
        .clock(clk), .reset_n(reset_n), .flush(flush),
        .ch_valid(fx_valid), .ch_ready(fx_ready), .ch_rd(fx_rd),
        .ch_need_to_wb(fx_need), .ch_is_load(fx_load), .ch_is_ls(fx_ls),
        .ch_ls_address(fx_addr), .ch_result(fx_res), .ch_pc(fx_pc), .ch_instr(fx_instr),
        .regfile_write_valid(fx_wen), .regfile_write_rd(fx_wrd), .regfile_write_data(fx_wdata),
        .wb_byp_need_to_wb(fx_bneed), .wb_byp_rd(fx_brd), .wb_byp_result(fx_bres),
        .commit_valid(fx_cv), .commit_rfwen(fx_crf), .commit_skip(fx_csk),
        .commit_rd(fx_crd), .commit_pc(fx_cpc), .commit_instr(fx_cinstr),
        .commit_count(fx_ccnt)
    );

    wb_commit_arbiter #(.NUM_CH(3), .XLEN(64), .ARB_MODE(1)) u_rr (
        .clock(clk), .reset_n(reset_n), .flush(flush),
        .ch_valid(rr_valid), .ch_ready(rr_ready), .ch_rd(rr_rd),
        .ch_need_to_wb(rr_need), .ch_is_load(rr_load), .ch_is_ls(rr_ls),
        .ch_ls_address(rr_addr), .ch_result(rr_res), .ch_pc(rr_pc), .ch_instr(rr_instr),
        .regfile_write_valid(rr_wen), .regfile_write_rd(rr_wrd), .regfile_write_data(rr_wdata),
        .wb_byp_need_to_wb(rr_bneed), .wb_byp_rd(rr_brd), .wb_byp_result(rr_bres),
        .commit_valid(rr_cv), .commit_rfwen(rr_crf), .commit_skip(rr_csk),
        .commit_rd(rr_crd), .commit_pc(rr_cpc), .commit_instr(rr_cinstr),
        .commit_count(rr_ccnt)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fx_valid = '0; fx_need = '0; fx_load = '0; fx_ls = '0; fx_rd = '0;
        fx_addr = '0; fx_res = '0; fx_pc = '0; fx_instr = '0;
        rr_valid = '0; rr_need = '0; rr_load = '0; rr_ls = '0; rr_rd = '0;
        rr_addr = '0; rr_res = '0; rr_pc = '0; rr_instr = '0;
    endtask

    task automatic fx_set(input int c, input logic v, input logic [4:0] rd, input logic need,
                          input logic ld, input logic ls, input logic [63:0] addr,
                          input logic [63:0] res, input logic [63:0] pc, input logic [31:0] ins);
        fx_valid[c] = v; fx_rd[c*5 +: 5] = rd; fx_need[c] = need; fx_load[c] = ld;
        fx_ls[c] = ls; fx_addr[c*64 +: 64] = addr; fx_res[c*64 +: 64] = res;
        fx_pc[c*64 +: 64] = pc; fx_instr[c*32 +: 32] = ins;
    endtask

    task automatic rr_set(input int c, input logic v, input logic [4:0] rd, input logic [63:0] res);
        rr_valid[c] = v; rr_rd[c*5 +: 5] = rd; rr_need[c] = 1'b1; rr_load[c] = 1'b0;
        rr_ls[c] = 1'b0; rr_addr[c*64 +: 64] = '0; rr_res[c*64 +: 64] = res;
        rr_pc[c*64 +: 64] = 64'h1000 + 64'(c * 4); rr_instr[c*32 +: 32] = 32'h33;
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic        need;
        logic        ld;
        logic        ls;
        logic [63:0] addr;
        logic [63:0] res;
        logic        exp_wen;
        logic        exp_skip;
    } vec_t;

    vec_t vt [9];
    logic [63:0] exp_cnt;
    logic [63:0] pc;

    initial begin
        vt[0] = '{5'd5,  1'b1, 1'b0, 1'b0, 64'h0,         64'h1234, 1'b1, 1'b0};
        vt[1] = '{5'd7,  1'b1, 1'b1, 1'b1, 64'h3000_0008, 64'hdead, 1'b0, 1'b1};
        vt[2] = '{5'd7,  1'b1, 1'b1, 1'b1, 64'h4070_0001, 64'hbeef, 1'b1, 1'b0};
        vt[3] = '{5'd0,  1'b1, 1'b0, 1'b0, 64'h0,         64'h55,   1'b0, 1'b0};
        vt[4] = '{5'd9,  1'b0, 1'b0, 1'b0, 64'h0,         64'h66,   1'b0, 1'b0};
        vt[5] = '{5'd10, 1'b1, 1'b1, 1'b1, 64'h4070_0000, 64'h77,   1'b0, 1'b1};
        vt[6] = '{5'd11, 1'b1, 1'b1, 1'b1, 64'h2fff_ffff, 64'h88,   1'b1, 1'b0};
        vt[7] = '{5'd12, 1'b1, 1'b0, 1'b1, 64'h3000_0000, 64'h99,   1'b1, 1'b1};
        vt[8] = '{5'd13, 1'b1, 1'b1, 1'b0, 64'h3000_0010, 64'haa,   1'b1, 1'b0};

        clear_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();

        chk("reset_ready_fx", 64'(fx_ready), 64'(2'b11));
        chk("reset_ready_rr", 64'(rr_ready), 64'(3'b111));
        chk("reset_wen", 64'(fx_wen), 64'd0);
        chk("reset_wdata", fx_wdata, 64'd0);
        chk("reset_cv", 64'(fx_cv), 64'd0);
        chk("reset_cnt", fx_ccnt, 64'd0);

        // single-channel vector table through ch0 of the fixed instance
        exp_cnt = '0;
        for (int k = 0; k < 9; k++) begin
            pc = 64'h8000_0000 + 64'(k * 4);
            fx_set(0, 1'b1, vt[k].rd, vt[k].need, vt[k].ld, vt[k].ls, vt[k].addr,
                   vt[k].res, pc, 32'h13 + 32'(k));
            step();
            fx_valid = '0;
            chk("lat_no_early_wen", 64'(fx_wen), 64'd0);
            step();
            chk("wen", 64'(fx_wen), 64'(vt[k].exp_wen));
            chk("byp_need", 64'(fx_bneed), 64'(vt[k].exp_wen));
            chk("wrd", 64'(fx_wrd), 64'(vt[k].rd));
            chk("wdata", fx_wdata, vt[k].res);
            chk("byp_res", fx_bres, vt[k].res);
            step();
            if (vt[k].exp_wen || !vt[k].exp_wen) exp_cnt = exp_cnt + 64'(DT);
            chk("cv", 64'(fx_cv), 64'(DT));
            chk("crfwen", 64'(fx_crf), 64'(DT & vt[k].exp_wen));
            chk("cskip", 64'(fx_csk), 64'(DT & vt[k].exp_skip));
            chk("crd", 64'(fx_crd), DT ? 64'(vt[k].rd) : 64'd0);
            chk("cpc", fx_cpc, DT ? pc : 64'd0);
            chk("cinstr", 64'(fx_cinstr), DT ? 64'(32'h13 + 32'(k)) : 64'd0);
            chk("ccount", fx_ccnt, exp_cnt);
            step();
            chk("cv_idle", 64'(fx_cv), 64'd0);
        end

        // fixed priority contention: ch1 starves while ch0 stays occupied
        fx_set(0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 64'h0, 64'h100, 64'h0, 32'h0);
        fx_set(1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 64'h0, 64'h200, 64'h0, 32'h0);
        step();
        for (int j = 0; j < 6; j++) begin
            chk("fx_ready_hold", 64'(fx_ready), 64'(2'b01));
            step();
            chk("fx_wen_cont", 64'(fx_wen), 64'd1);
            chk("fx_wrd_cont", 64'(fx_wrd), 64'd10);
        end
        fx_valid[0] = 1'b0;
        step();
        chk("fx_last_ch0", 64'(fx_wrd), 64'd10);
        step();
        chk("fx_ch1_wins", 64'(fx_wrd), 64'd11);
        chk("fx_ch1_data", fx_wdata, 64'h200);
        fx_valid = '0;
        step();
        step();
        step();
        chk("fx_drained", 64'(fx_wen), 64'd0);

        // round-robin contention on 3 channels, all valid every cycle
        for (int c = 0; c < 3; c++) rr_set(c, 1'b1, 5'(c + 1), 64'h40 + 64'(c));
        step();
        for (int j = 0; j < 9; j++) begin
            chk("rr_ready_onehot", 64'(rr_ready), 64'(3'b001 << (j % 3)));
            step();
            chk("rr_wen", 64'(rr_wen), 64'd1);
            chk("rr_order", 64'(rr_wrd), 64'((j % 3) + 1));
        end

        // reset mid-stream drops everything
        reset_n = 1'b0;
        #1;
        chk("mid_reset_wen", 64'(rr_wen), 64'd0);
        chk("mid_reset_wrd", 64'(rr_wrd), 64'd0);
        chk("mid_reset_wdata", rr_wdata, 64'd0);
        chk("mid_reset_cv", 64'(rr_cv), 64'd0);
        chk("mid_reset_cnt_rr", rr_ccnt, 64'd0);
        chk("mid_reset_cnt_fx", fx_ccnt, 64'd0);
        clear_inputs();
        step();
        reset_n = 1'b1;
        step();
        chk("post_reset_wen", 64'(rr_wen), 64'd0);

        // flush with two buffered entries, WB valid and a commit registered
        for (int c = 0; c < 3; c++) rr_set(c, 1'b1, 5'(c + 1), 64'ha0 + 64'(c));
        step();
        rr_valid = 3'b000;
        rr_set(0, 1'b1, 5'd4, 64'hd0);
        step();
        chk("fl_wb_ch0", 64'(rr_wrd), 64'd1);
        rr_valid = '0;
        step();
        chk("fl_wb_ch1", 64'(rr_wrd), 64'd2);
        chk("fl_cv_pre", 64'(rr_cv), 64'(DT));
        chk("fl_crd_pre", 64'(rr_crd), DT ? 64'd1 : 64'd0);
        flush = 1'b1;
        rr_set(1, 1'b1, 5'd9, 64'hee);
        #1;
        chk("fl_ready_zero", 64'(rr_ready), 64'd0);
        chk("fl_cv_during", 64'(rr_cv), 64'(DT));
        step();
        flush = 1'b0;
        rr_valid = '0;
        for (int j = 0; j < 4; j++) begin
            chk("fl_no_write", 64'(rr_wen), 64'd0);
            chk("fl_no_commit", 64'(rr_cv), 64'd0);
            step();
        end
        chk("fl_count", rr_ccnt, DT ? 64'd1 : 64'd0);

        // pointer survived the flush: ch2 goes first
        for (int c = 0; c < 3; c++) rr_set(c, 1'b1, 5'(c + 1), 64'hb0 + 64'(c));
        step();
        rr_valid = '0;
        step();
        chk("ptr_kept_ch2", 64'(rr_wrd), 64'd3);
        step();
        chk("ptr_wrap_ch0", 64'(rr_wrd), 64'd1);
        step();
        chk("ptr_next_ch1", 64'(rr_wrd), 64'd2);
        chk("ptr_next_data", rr_wdata, 64'hb1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
